// File: rtl/dff_input_debouncer_if.sv
// Bundles the enable, raw pad inputs and the conditioned outputs of the
// input debouncer so the producer/consumer sides share one port.
interface dff_input_debouncer_if #(
    parameter int WIDTH = 8
);
    logic             ena;
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] d_clean;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             load;
    logic [7:0]       event_cnt;

    modport master (
        output ena, raw_in,
        input  d_clean, rise, fall, load, event_cnt
    );

    modport slave (
        input  ena, raw_in,
        output d_clean, rise, fall, load, event_cnt
    );
endinterface

// File: rtl/dff_input_debouncer.sv
// Per-bit two-flop synchroniser plus stability-counter debouncer, with
// rise/fall strobes, a combined load strobe and a wrapping event counter.

module dff_input_debouncer_lane #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic accept
);
    localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       s1;
    logic       s2;
    logic [7:0] cnt;
    logic       mismatch;

    assign mismatch = s2 ^ level;
    // Acceptance is decided combinationally so the top can form load from
    // the next-state strobes and keep it coincident with the level change.
    assign accept   = ena && mismatch && (cnt >= LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= 8'd0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= accept && s2;
            fall <= accept && !s2;
            if (accept) begin
                level <= s2;
                cnt   <= 8'd0;
            end else if (ena && mismatch) begin
                cnt <= cnt + 8'd1;
            end else begin
                cnt <= 8'd0;
            end
        end
    end
endmodule

module dff_input_debouncer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    dff_input_debouncer_if.slave  bus
);
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] accept;
    logic             load;
    logic [7:0]       event_cnt;
    logic             any_accept;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        dff_input_debouncer_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .ena   (bus.ena),
            .raw   (bus.raw_in[i]),
            .level (level[i]),
            .rise  (rise[i]),
            .fall  (fall[i]),
            .accept(accept[i])
        );
    end

    // Several bits accepted on one edge still count as a single event.
    assign any_accept = |accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load      <= 1'b0;
            event_cnt <= 8'd0;
        end else begin
            load <= any_accept;
            if (any_accept)
                event_cnt <= event_cnt + 8'd1;
        end
    end

    assign bus.d_clean   = level;
    assign bus.rise      = rise;
    assign bus.fall      = fall;
    assign bus.load      = load;
    assign bus.event_cnt = event_cnt;
endmodule

// File: tb/tb_dff_input_debouncer.sv
// Randomised and directed bench for dff_input_debouncer, checked every cycle
// against a window-based behavioural model of the acceptance rule.
module tb_dff_input_debouncer;
    localparam int W  = 8;
    localparam int DC = 16;
    localparam int D  = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dff_input_debouncer_if #(.WIDTH(W)) bus();

    dff_input_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an edge accepts a bit when the last DC edges all had ena=1, a
    // synchronised value (raw two edges earlier) differing from the clean
    // level, and none of them lies at or before that bit's last acceptance.
    logic [W-1:0] rh [D];
    bit           eh [D];
    int           n;
    int           last_acc [W];
    logic [W-1:0] m_clean, m_rise, m_fall;
    logic         m_load;
    logic [7:0]   m_evt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n = 0;
            m_clean = '0; m_rise = '0; m_fall = '0; m_load = 1'b0; m_evt = 8'd0;
            for (int i = 0; i < W; i++) last_acc[i] = 0;
            for (int e = 0; e < D; e++) begin rh[e] = '0; eh[e] = 1'b0; end
        end else begin
            n++;
            rh[n % D] = bus.raw_in;
            eh[n % D] = bus.ena;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < W; i++) begin
                bit acc;
                acc = 1'b1;
                for (int j = 0; j < DC; j++) begin
                    int   e;
                    logic sv;
                    e = n - j;
                    if (e < 1 || e <= last_acc[i] || !eh[e % D]) acc = 1'b0;
                    else begin
                        sv = (e >= 3) ? rh[(e - 2) % D][i] : 1'b0;
                        if (sv == m_clean[i]) acc = 1'b0;
                    end
                end
                if (acc) begin
                    last_acc[i] = n;
                    if (m_clean[i]) m_fall[i] = 1'b1;
                    else            m_rise[i] = 1'b1;
                end
            end
            m_clean = m_clean ^ (m_rise | m_fall);
            m_load  = |(m_rise | m_fall);
            m_evt   = m_evt + {7'd0, m_load};
        end
    end

    int loads_seen = 0;
    int rise0_seen = 0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_d_clean", bus.d_clean,   m_clean);
            chk("model_rise",    bus.rise,      m_rise);
            chk("model_fall",    bus.fall,      m_fall);
            chk("model_load",    bus.load,      m_load);
            chk("model_evt",     bus.event_cnt, m_evt);
            if (bus.load)    loads_seen++;
            if (bus.rise[0]) rise0_seen++;
        end
    end

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        int ena_left;
        bus.raw_in = 8'hFF;
        bus.ena    = 1'b0;
        rst        = 1'b1;

        // Reset with inputs high: everything must read zero.
        tick(3);
        chk("rst_d_clean", bus.d_clean, 8'h00);
        chk("rst_rise", bus.rise, 8'h00);
        chk("rst_fall", bus.fall, 8'h00);
        chk("rst_load", bus.load, 1'b0);
        chk("rst_evt", bus.event_cnt, 8'd0);
        rst = 1'b0;
        bus.ena = 1'b1;
        tick(17);
        chk("lat17_d_clean", bus.d_clean, 8'h00);
        tick(1);
        chk("lat18_d_clean", bus.d_clean, 8'hFF);
        chk("lat18_rise", bus.rise, 8'hFF);
        chk("lat18_load", bus.load, 1'b1);
        chk("lat18_evt", bus.event_cnt, 8'd1);
        tick(1);
        chk("pulse_end_rise", bus.rise, 8'h00);
        chk("pulse_end_load", bus.load, 1'b0);

        // Bounce on bit 0.
        bus.raw_in = 8'h00;
        tick(20);
        rise0_seen = 0;
        bus.raw_in = 8'h01;
        tick(10);
        bus.raw_in = 8'h00;
        tick(1);
        bus.raw_in = 8'h01;
        tick(17);
        chk("bounce17_d0", bus.d_clean[0], 1'b0);
        tick(1);
        chk("bounce18_d0", bus.d_clean[0], 1'b1);
        chk("bounce18_rise0", bus.rise[0], 1'b1);
        tick(3);
        chk("bounce_rise_pulses", rise0_seen, 1);

        // Multi-bit rise and fall on one edge.
        bus.raw_in = 8'h0F;
        tick(20);
        bus.raw_in = 8'hF0;
        tick(17);
        chk("multi17_d_clean", bus.d_clean, 8'h0F);
        tick(1);
        chk("multi_rise", bus.rise, 8'hF0);
        chk("multi_fall", bus.fall, 8'h0F);
        chk("multi_load", bus.load, 1'b1);
        chk("multi_evt", bus.event_cnt, 8'd5);
        tick(1);
        chk("multi_load_end", bus.load, 1'b0);
        chk("multi_evt_hold", bus.event_cnt, 8'd5);

        // Enable drop at count 8, five cycles off.
        bus.raw_in = 8'hF2;
        tick(10);
        bus.ena = 1'b0;
        loads_seen = 0;
        tick(5);
        chk("ena_off_loads", loads_seen, 0);
        chk("ena_off_d_clean", bus.d_clean, 8'hF0);
        bus.ena = 1'b1;
        tick(15);
        chk("ena15_d_clean", bus.d_clean, 8'hF0);
        tick(1);
        chk("ena16_d_clean", bus.d_clean, 8'hF2);
        chk("ena16_rise", bus.rise, 8'h02);
        chk("ena16_evt", bus.event_cnt, 8'd6);

        // Random bouncing inputs and enable drops.
        ena_left = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [W-1:0] r;
            r = bus.raw_in;
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 39) == 0) r[b] = ~r[b];
            bus.raw_in = r;
            if (ena_left > 0) begin
                ena_left--;
                bus.ena = 1'b0;
            end else if ($urandom_range(0, 199) == 0) begin
                ena_left = $urandom_range(1, 8);
                bus.ena = 1'b0;
            end else begin
                bus.ena = 1'b1;
            end
            tick(1);
        end

        // Event counter wrap after 256 events from reset.
        rst = 1'b1;
        bus.raw_in = 8'h00;
        bus.ena = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(20);
        loads_seen = 0;
        for (int k = 0; k < 256; k++) begin
            bus.raw_in[2] = ~bus.raw_in[2];
            tick(19);
            if (k == 254) chk("wrap_evt_255", bus.event_cnt, 8'd255);
        end
        chk("wrap_loads", loads_seen, 256);
        chk("wrap_evt_0", bus.event_cnt, 8'd0);

        // Reset during a pending change clears outputs at once.
        bus.raw_in = 8'h0F;
        tick(20);
        chk("pre_rst_d_clean", bus.d_clean, 8'h0F);
        bus.raw_in = 8'hF0;
        tick(14);
        chk("pre_rst_rise", bus.rise, 8'h00);
        rst = 1'b1;
        #1;
        chk("async_d_clean", bus.d_clean, 8'h00);
        chk("async_rise", bus.rise, 8'h00);
        chk("async_fall", bus.fall, 8'h00);
        chk("async_load", bus.load, 1'b0);
        chk("async_evt", bus.event_cnt, 8'd0);
        tick(2);
        rst = 1'b0;
        tick(17);
        chk("rerel17_d_clean", bus.d_clean, 8'h00);
        tick(1);
        chk("rerel18_d_clean", bus.d_clean, 8'hF0);
        chk("rerel18_rise", bus.rise, 8'hF0);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
